uart_rx_8n1: RTL and testbench
==============================

Name: uart_rx_8n1

Overview:
- Asynchronous serial receiver, 8N1 framing: 1 start bit, 8 data bits LSB first, no parity, 1 stop bit.
- Oversamples the RX line at 16x baud using a tick generator derived from the system clock.
- Delivers each received byte on DATA with a one-cycle STATUS strobe.
- Sits between the board serial pin and the CPU's memory-mapped UART peripheral register.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 9600: serial bit rate.
- OVERSAMPLE, 16: ticks per bit; fixed at 16, must not be overridden.
- Derived constant DIV = CLK_FREQ/(BAUD*16), integer-truncated; 325 at defaults. One 16x tick every DIV clocks.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- RX  input  1  serial line, idle high; asynchronous to clk.
- DATA  output  8  last correctly received byte; holds until the next byte completes.
- STATUS  output  1  one-clk-cycle high pulse when DATA is updated.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, DATA=8'h00, STATUS=0, all counters 0, synchronizer flops=1 (idle level).
- RX passes through a 2-flop synchronizer before any use.
  - All timing below refers to the synchronized signal rx_s.
  - rx_s lags RX by 2 clk cycles.
- Tick generator:
  - Counter counts 0..DIV-1 and asserts tick for one clk when it wraps.
  - The counter is cleared when IDLE detects a start edge, so sampling phase locks to the frame.
- State machine:
  - IDLE:
    - On rx_s high-to-low transition: clear tick counter and sample counter; go to START.
  - START:
    - Count 8 ticks (mid start bit), then sample rx_s.
    - If rx_s=1 (glitch): return to IDLE, no output.
    - If rx_s=0: clear sample counter and bit index; go to DATA.
  - DATA:
    - Every 16 ticks, sample rx_s into shift register bit[bit index], LSB first.
    - After bit 7 is sampled: go to STOP.
  - STOP:
    - After 16 ticks, sample rx_s.
    - If rx_s=1: load DATA with the shift register and pulse STATUS high for exactly one clk.
    - Stop-bit=0 handling: see Optional Feature.
    - Return to IDLE in the same cycle.
- Timing: STATUS rises at approximately 9.5 bit times after the RX falling edge, plus the 2-cycle synchronizer delay and up to one clk of register delay.
- Back-to-back frames: a new start edge is accepted in IDLE immediately after STOP, so frames may be separated by the stop bit only.
- RX held low continuously (break):
  - A frame completes with stop=0.
  - The FSM then waits in IDLE for a new high-to-low edge.
  - It does not retrigger while the line stays low.
- Reset mid-frame: the frame is abandoned; DATA returns to 0; no STATUS pulse.
- Tolerance: correct reception with combined baud mismatch up to ±3%.

Optional Feature:
- Macro UART_RX_FRAME_CHECK_EN.
- Defined: a frame whose stop-bit sample is 0 is discarded. DATA is unchanged, STATUS stays 0, and the FSM returns to IDLE.
- Not defined: the stop bit value is ignored. DATA is loaded and STATUS pulses for every frame that reaches STOP.
- Port list is identical in both builds.

Test Plan:
- Reset: hold rst=0 for 5 clks with RX=1 -> DATA=8'h00, STATUS=0. After release with RX idle for 10,000 clks, STATUS never pulses.
- Single byte (defaults; bit time 5208 clks, clk period 20 ns):
  - Start bit, then data bits 1,1,1,0,1,0,0,1, then stop=1.
  - Expect: DATA=8'h97, and exactly one STATUS pulse, one clk wide, about 9.5 bit times after the start edge.
- Second byte after a 3-bit-time idle gap: data bits 0,1,1,0,1,0,1,0, stop=1 -> DATA=8'h56, one STATUS pulse. DATA stays 8'h97 until that pulse.
- Glitch rejection: drive RX low for 100 clks, then back high -> no STATUS, FSM back in IDLE, DATA unchanged.
- Framing: send 8'hA5 with stop bit=0.
  - With UART_RX_FRAME_CHECK_EN: no STATUS, DATA unchanged.
  - Without it: DATA=8'hA5 and STATUS pulses.
- Reset mid-frame: assert rst during data bit 4, release, then send 8'h3C -> DATA=8'h00 after reset, then DATA=8'h3C with exactly one STATUS pulse.

Source files
------------

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 asynchronous serial receiver with 16x oversampling.
// RX is synchronized through two flops, then a start/data/stop FSM samples
// the line at mid-bit. It uses a tick generator that restarts on every start edge.
// The optional macro UART_RX_FRAME_CHECK_EN discards frames whose stop bit
// samples low. Without the macro, every frame that reaches the stop bit is delivered.
module uart_rx_8n1 #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    output logic [7:0] DATA,
    output logic       STATUS
);

    // clocks per 16x tick; OVERSAMPLE is expected to stay at 16
    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] DIV_LAST = TW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          state, state_nx;
    logic            rx_m, rx_s, rx_d;
    logic [TW-1:0]   tcnt;
    logic            tick, tclr;
    logic [3:0]      scnt, scnt_nx;
    logic [2:0]      bidx, bidx_nx;
    logic [7:0]      shreg, shreg_nx;
    logic [7:0]      data_nx;
    logic            status_nx;

    assign tick = (tcnt == DIV_LAST);

    // two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= RX;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    // 16x tick counter, re-phased to the frame when a start edge is seen
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt <= '0;
        end else if (tclr || tick) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end

    // FSM state, counters, shift register and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            scnt   <= '0;
            bidx   <= '0;
            shreg  <= '0;
            DATA   <= '0;
            STATUS <= 1'b0;
        end else begin
            state  <= state_nx;
            scnt   <= scnt_nx;
            bidx   <= bidx_nx;
            shreg  <= shreg_nx;
            DATA   <= data_nx;
            STATUS <= status_nx;
        end
    end

    // next-state logic: mid-start check, 16-tick data/stop sampling
    always_comb begin
        state_nx  = state;
        scnt_nx   = scnt;
        bidx_nx   = bidx;
        shreg_nx  = shreg;
        data_nx   = DATA;
        status_nx = 1'b0;
        tclr      = 1'b0;
        case (state)
            S_IDLE: begin
                if (rx_d && !rx_s) begin
                    tclr     = 1'b1;
                    scnt_nx  = '0;
                    state_nx = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (scnt == 4'd7) begin
                        scnt_nx = '0;
                        if (rx_s) begin
                            // line went back high before mid start bit: glitch
                            state_nx = S_IDLE;
                        end else begin
                            bidx_nx  = '0;
                            state_nx = S_DATA;
                        end
                    end else begin
                        scnt_nx = scnt + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    // 4-bit counter wraps 15 -> 0, giving one sample per 16 ticks
                    scnt_nx = scnt + 4'd1;
                    if (scnt == 4'd15) begin
                        shreg_nx[bidx] = rx_s;
                        bidx_nx        = bidx + 3'd1;
                        if (bidx == 3'd7) begin
                            state_nx = S_STOP;
                        end
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    scnt_nx = scnt + 4'd1;
                    if (scnt == 4'd15) begin
                        state_nx = S_IDLE;
`ifdef UART_RX_FRAME_CHECK_EN
                        if (rx_s) begin
                            data_nx   = shreg;
                            status_nx = 1'b1;
                        end
`else
                        data_nx   = shreg;
                        status_nx = 1'b1;
`endif
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1: directed table of frames plus hand-written corner sequences
// (idle after reset, glitch, break, reset mid-frame) for uart_rx_8n1.
// Parameters are scaled so DIV = 10 and one bit lasts 160 clocks.
module tb_uart_rx_8n1;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int DIV      = 10;
    localparam int BIT      = 16 * DIV;
    localparam int LAT      = 152 * DIV;   // ticks from start edge to stop sample

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       RX  = 1'b1;
    logic [7:0] DATA;
    logic       STATUS;

    uart_rx_8n1 #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk    (clk),
        .rst    (rst),
        .RX     (RX),
        .DATA   (DATA),
        .STATUS (STATUS)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // STATUS monitor, sampled on the falling edge
    int   pulses = 0;
    int   last_pulse = 0;
    int   wide = 0;
    logic st_q = 1'b0;
    always @(negedge clk) begin
        if (STATUS === 1'b1) begin
            if (st_q) wide++;
            else begin
                pulses++;
                last_pulse = cyc;
            end
        end
        st_q = (STATUS === 1'b1);
    end

    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // start bit and 8 data bits; returns at the negedge where the stop bit begins
    task automatic send_head(input logic [7:0] b, input int bl, output int t0);
        @(negedge clk);
        RX = 1'b0;
        t0 = cyc;
        repeat (bl) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (bl) @(negedge clk);
        end
    endtask

    task automatic send_stop(input logic stop, input int bl);
        RX = stop;
        repeat (bl) @(negedge clk);
        RX = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        RX = 1'b1;
        repeat (n * BIT) @(negedge clk);
    endtask

    task automatic wait_pulse(input int p0, input int budget);
        for (int k = 0; k < budget && pulses == p0; k++) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] dbyte;
        logic       stop;
        int         gap;
        int         bl;
        int         exp_pulse;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vt[7];

    initial begin
        int t0, p0;
        logic [7:0] prev;

        vt[0] = '{8'h97, 1'b1, 1, BIT,      1, 8'h97};
        vt[1] = '{8'h56, 1'b1, 3, BIT,      1, 8'h56};
`ifdef UART_RX_FRAME_CHECK_EN
        vt[2] = '{8'hA5, 1'b0, 2, BIT,      0, 8'h56};
`else
        vt[2] = '{8'hA5, 1'b0, 2, BIT,      1, 8'hA5};
`endif
        vt[3] = '{8'h00, 1'b1, 1, BIT,      1, 8'h00};
        vt[4] = '{8'hFF, 1'b1, 1, BIT - 5,  1, 8'hFF};
        vt[5] = '{8'h5A, 1'b1, 1, BIT + 5,  1, 8'h5A};
        vt[6] = '{8'h01, 1'b1, 0, BIT,      1, 8'h01};

        // reset held with the line idle
        repeat (5) @(negedge clk);
        chk("reset_data", DATA, 8'h00);
        chk("reset_status", STATUS, 1'b0);
        rst = 1'b1;
        repeat (2000) @(negedge clk);
        chk("idle_no_pulse", pulses, 0);

        // table of frames
        prev = 8'h00;
        for (int i = 0; i < 7; i++) begin
            idle_bits(vt[i].gap);
            p0 = pulses;
            send_head(vt[i].dbyte, vt[i].bl, t0);
            chk($sformatf("v%0d_mid_data", i), DATA, prev);
            chk($sformatf("v%0d_mid_pulses", i), pulses - p0, 0);
            send_stop(vt[i].stop, vt[i].bl);
            if (vt[i].exp_pulse != 0) wait_pulse(p0, 2 * BIT);
            chk($sformatf("v%0d_pulses", i), pulses - p0, vt[i].exp_pulse);
            chk($sformatf("v%0d_data", i), DATA, vt[i].exp_data);
            if (vt[i].exp_pulse != 0 && pulses != p0)
                chk_range($sformatf("v%0d_latency", i), last_pulse - t0, LAT + 1, LAT + 5);
            prev = vt[i].exp_data;
        end

        // glitch: low far shorter than half a bit
        idle_bits(2);
        p0 = pulses;
        RX = 1'b0;
        repeat (40) @(negedge clk);
        RX = 1'b1;
        repeat (12 * BIT) @(negedge clk);
        chk("glitch_pulses", pulses - p0, 0);
        chk("glitch_data", DATA, prev);
        send_head(8'hC3, BIT, t0);
        send_stop(1'b1, BIT);
        wait_pulse(p0, 2 * BIT);
        chk("after_glitch_pulses", pulses - p0, 1);
        chk("after_glitch_data", DATA, 8'hC3);
        prev = 8'hC3;

        // break: line held low for many bit times
        idle_bits(2);
        p0 = pulses;
        RX = 1'b0;
        repeat (14 * BIT) @(negedge clk);
`ifdef UART_RX_FRAME_CHECK_EN
        chk("break_pulses", pulses - p0, 0);
        chk("break_data", DATA, prev);
`else
        chk("break_pulses", pulses - p0, 1);
        chk("break_data", DATA, 8'h00);
`endif
        RX = 1'b1;
        p0 = pulses;
        repeat (12 * BIT) @(negedge clk);
        chk("break_release_pulses", pulses - p0, 0);

        // reset during data bit 4
        p0 = pulses;
        @(negedge clk);
        RX = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            RX = (8'h3C >> i) & 8'h01;
            repeat (BIT) @(negedge clk);
        end
        RX = 1'b1;
        repeat (BIT / 2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("midreset_data", DATA, 8'h00);
        chk("midreset_status", STATUS, 1'b0);
        rst = 1'b1;
        repeat (12 * BIT) @(negedge clk);
        chk("midreset_pulses", pulses - p0, 0);
        chk("midreset_hold", DATA, 8'h00);
        p0 = pulses;
        send_head(8'h3C, BIT, t0);
        send_stop(1'b1, BIT);
        wait_pulse(p0, 2 * BIT);
        chk("post_reset_pulses", pulses - p0, 1);
        chk("post_reset_data", DATA, 8'h3C);
        repeat (2 * BIT) @(negedge clk);
        chk("post_reset_single", pulses - p0, 1);

        chk("status_width", wide, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
